multicycle_main_fsm: RTL

//  Main sequencer for the multicycle ARM datapath.
//  - Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
//  - Drives mux selects and raw write strobes. Condition gating is downstream.
//  - Sits beside the instruction decoder and condition logic inside the multicycle controller.
//  - Handles memory wait states with a watchdog (optional feature).

---
 rtl/multicycle_main_fsm.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// Main sequencer for the multicycle ARM datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath
// mux selects plus raw (ungated) write strobes; condition gating happens downstream.
// Optional feature: define MULTICYCLE_FSM_WAIT_EN to make FETCH/MEMREAD/MEMWRITE wait on
// mem_ready, with a watchdog that aborts an access after MAX_WAIT stalled cycles.
module multicycle_main_fsm #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       branch,
    output logic       reg_w,
    output logic       mem_w,
    output logic       alu_op,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       undef,
    output logic       bus_err,
    output logic [3:0] state
);

    // State codes are visible on the debug port, so they are fixed values.
    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;

    localparam logic [1:0] OpDataProc = 2'b00;
    localparam logic [1:0] OpMemory   = 2'b01;
    localparam logic [1:0] OpBranch   = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResRdData = 2'b01;
    localparam logic [1:0] ResAluDir = 2'b10;

    // Reject out-of-range watchdog limits at elaboration time.
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("multicycle_main_fsm: MAX_WAIT must be in 1..255");
    end

    logic [3:0] state_q, state_d;
    logic       undef_raw;
    logic       advance;   // current wait state may move on this cycle
    logic       timeout;   // current access is aborted this cycle

    // Only the I and L bits of funct matter to the sequencer.
    logic unused_funct;
    assign unused_funct = ^funct[4:1];

`ifdef MULTICYCLE_FSM_WAIT_EN
    localparam logic [7:0] WaitLimit = 8'(MAX_WAIT - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       in_wait;

    // Classify the current state for the memory handshake and watchdog.
    always_comb begin
        in_wait = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
        advance = !in_wait || mem_ready;
        // Completion in the expiry cycle wins because timeout requires mem_ready=0.
        timeout = in_wait && !mem_ready && (wait_cnt_q == WaitLimit);
    end

    // Count consecutive stalled cycles of one access; any progress or abort clears it.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (in_wait && !mem_ready && !timeout && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Without wait states every state lasts one cycle and mem_ready is ignored.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign advance          = 1'b1;
    assign timeout          = 1'b0;
`endif

    // Next-state sequencing, including the undefined-op detect in DECODE.
    always_comb begin
        state_d   = state_q;
        undef_raw = 1'b0;
        case (state_q)
            StFetch: begin
                if (timeout) begin
                    state_d = StFetch;
                end else if (advance) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (op)
                    OpDataProc: state_d = funct[5] ? StExecI : StExecR;
                    OpMemory:   state_d = StMemAdr;
                    OpBranch:   state_d = StBranch;
                    default: begin
                        state_d   = StFetch;
                        undef_raw = 1'b1;
                    end
                endcase
            end
            StMemAdr:   state_d = funct[0] ? StMemRead : StMemWrite;
            StMemRead: begin
                if (timeout) begin
                    state_d = StFetch;
                end else if (advance) begin
                    state_d = StMemWb;
                end
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (timeout || advance) begin
                    state_d = StFetch;
                end
            end
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;  // codes 10-15 recover to FETCH
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of selects and strobes; strobes are masked while reset is held.
    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        result_src = ResAluOut;
        case (state_q)
            StFetch: begin
                // An aborted fetch never reaches here with advance=1.
                ir_write   = advance;
                next_pc    = advance;
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluDir;
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluDir;
            end
            StMemAdr: begin
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResRdData;
                reg_w      = 1'b1;
            end
            StMemWrite: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;  // held for the whole residency as the write request
            end
            StExecR: begin
                alu_op = 1'b1;
            end
            StExecI: begin
                alu_src_b = SrcBImm;
                alu_op    = 1'b1;
            end
            StAluWb: begin
                reg_w = 1'b1;
            end
            StBranch: begin
                alu_src_b  = SrcBImm;
                result_src = ResAluDir;
                branch     = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            ir_write = 1'b0;
            next_pc  = 1'b0;
            branch   = 1'b0;
            reg_w    = 1'b0;
            mem_w    = 1'b0;
        end
    end

    assign undef   = undef_raw && !reset;
    assign bus_err = timeout && !reset;
    assign state   = state_q;

endmodule
